// File: rtl/crossing_pkg.sv
// Shared state encoding and light-pattern constants for the crossing scheduler.
package crossing_pkg;

   typedef enum logic [2:0] {
      GAP        = 3'd0,
      READY      = 3'd1,
      START      = 3'd2,
      WAIT_LEAVE = 3'd3,
      RUN        = 3'd4,
      FAULT      = 3'd5
   } state_t;

   // Traffic green with crossing red: the resting pattern of the light FSM.
   localparam logic [5:0] IDLE_PAT = 6'b001_100;

   localparam int TRAF_R  = 5;
   localparam int TRAF_A  = 4;
   localparam int TRAF_G  = 3;
   localparam int CROSS_R = 2;
   localparam int CROSS_A = 1;
   localparam int CROSS_G = 0;

endpackage

// File: rtl/req_sync.sv
// Brings one asynchronous push-button into the clock domain and emits a
// single-cycle pulse on each new press.
module req_sync (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= button;
         sync <= meta;
         prev <= sync;
      end
   end

   assign pulse = sync & ~prev;

endmodule

// File: rtl/crossing_scheduler.sv
// Latches crossing requests, enforces a traffic-green gap between phases,
// starts the light FSM and watches it with a sticky-fault watchdog.
module crossing_scheduler
   import crossing_pkg::*;
#(
   parameter int MIN_GAP     = 16,
   parameter int SEQ_TIMEOUT = 64,
   parameter int COUNT_W     = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ped_req,
   input  logic               cyc_req,
   input  logic [5:0]         lightseq_in,
   output logic               tl_start,
   output logic               ped_wait,
   output logic               cyc_wait,
   output logic               busy,
   output logic               fault,
   output logic [COUNT_W-1:0] served_count
);

   localparam int GAP_W = $clog2(MIN_GAP + 1);
   localparam int TO_W  = $clog2(SEQ_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SEQ_TIMEOUT - 1);

   state_t           state;
   state_t           next_state;
   logic [GAP_W-1:0] gap_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             ped_pend;
   logic             cyc_pend;
   logic             ped_edge;
   logic             cyc_edge;
   logic             idle;

   req_sync u_ped_sync (
      .clock  (clock),
      .reset  (reset),
      .button (ped_req),
      .pulse  (ped_edge)
   );

   req_sync u_cyc_sync (
      .clock  (clock),
      .reset  (reset),
      .button (cyc_req),
      .pulse  (cyc_edge)
   );

   assign idle = (lightseq_in == IDLE_PAT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= GAP;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         GAP: begin
            if (idle && gap_cnt == GAP_LAST) begin
               next_state = READY;
            end
         end
         READY: begin
            if ((ped_pend | cyc_pend) && idle) begin
               next_state = START;
            end
         end
         START: begin
            next_state = WAIT_LEAVE;
         end
         WAIT_LEAVE: begin
            if (!idle) begin
               next_state = RUN;
            end else if (to_cnt == TO_LAST) begin
               next_state = FAULT;
            end
         end
         RUN: begin
            if (idle) begin
               next_state = GAP;
            end else if (to_cnt == TO_LAST) begin
               next_state = FAULT;
            end
         end
         FAULT: begin
            next_state = FAULT;
         end
         default: begin
            next_state = GAP;
         end
      endcase
   end

   // Counters restart on every state change, so neither can wrap; a press seen
   // during START survives the clear and is served by the following phase.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gap_cnt      <= '0;
         to_cnt       <= '0;
         ped_pend     <= 1'b0;
         cyc_pend     <= 1'b0;
         served_count <= '0;
      end else begin
         if (state == GAP && next_state == GAP && idle) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end else begin
            gap_cnt <= '0;
         end

         if ((state == WAIT_LEAVE || state == RUN) && next_state == state) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end

         if (state == START) begin
            ped_pend <= ped_edge;
            cyc_pend <= cyc_edge;
         end else begin
            ped_pend <= ped_pend | ped_edge;
            cyc_pend <= cyc_pend | cyc_edge;
         end

         if (state == RUN && next_state == GAP && served_count != '1) begin
            served_count <= served_count + COUNT_W'(1);
         end
      end
   end

   always_comb begin
      tl_start = 1'b0;
      busy     = 1'b0;
      fault    = 1'b0;
      case (state)
         START: begin
            tl_start = 1'b1;
            busy     = 1'b1;
         end
         WAIT_LEAVE, RUN: begin
            busy = 1'b1;
         end
         FAULT: begin
            fault = 1'b1;
         end
         default: begin
            tl_start = 1'b0;
         end
      endcase
   end

   assign ped_wait = ped_pend;
   assign cyc_wait = cyc_pend;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler; the light FSM is played by driving
// lightseq_in by hand and all timings are counted in clock edges.
module tb_crossing_scheduler;
   import crossing_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ped_req = 1'b0;
   logic       cyc_req = 1'b0;
   logic [5:0] lightseq_in = IDLE_PAT;
   logic       tl_start;
   logic       ped_wait;
   logic       cyc_wait;
   logic       busy;
   logic       fault;
   logic [7:0] served_count;
   logic [5:0] amber_pat;
   int         checks = 0;
   int         errors = 0;

   crossing_scheduler #(
      .MIN_GAP     (16),
      .SEQ_TIMEOUT (64),
      .COUNT_W     (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ped_req      (ped_req),
      .cyc_req      (cyc_req),
      .lightseq_in  (lightseq_in),
      .tl_start     (tl_start),
      .ped_wait     (ped_wait),
      .cyc_wait     (cyc_wait),
      .busy         (busy),
      .fault        (fault),
      .served_count (served_count)
   );

   always #5 clock = ~clock;

   // Every sample and every input change happens 1ns after a rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_start(input int limit, output int waited);
      waited = 0;
      while (tl_start !== 1'b1 && waited < limit) begin
         step(1);
         waited++;
      end
      if (tl_start !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_start: tl_start=%b after %0d cycles, required 1", tl_start, waited);
      end
   endtask

   task automatic apply_reset;
      ped_req     = 1'b0;
      cyc_req     = 1'b0;
      lightseq_in = IDLE_PAT;
      #2 reset = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic finish_phase(input int amber_cycles);
      lightseq_in = amber_pat;
      step(amber_cycles);
      lightseq_in = IDLE_PAT;
      step(1);
   endtask

   task automatic test_reset;
      int starts;
      starts = 0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({tl_start, ped_wait, cyc_wait, busy, fault, served_count} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b, required all 0",
                  {tl_start, ped_wait, cyc_wait, busy, fault, served_count});
      end
      step(2);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (tl_start === 1'b1) starts++;
      end
      checks++;
      if (starts !== 0) begin
         errors++;
         $display("[TB] FAIL idle_no_start: %0d start pulses, required 0", starts);
      end
      checks++;
      if ({busy, fault, ped_wait, cyc_wait, served_count} !== 12'd0) begin
         errors++;
         $display("[TB] FAIL idle_outputs: got %b, required all 0",
                  {busy, fault, ped_wait, cyc_wait, served_count});
      end
   endtask

   task automatic test_ped_request;
      ped_req = 1'b1;
      step(2);
      checks++;
      if (ped_wait !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ped_latency_early: ped_wait=%b, required 0", ped_wait);
      end
      step(1);
      checks++;
      if ({ped_wait, tl_start} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL ped_latency_3: ped_wait,tl_start=%b, required 10", {ped_wait, tl_start});
      end
      step(1);
      checks++;
      if ({tl_start, busy} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL ped_start: tl_start,busy=%b, required 11", {tl_start, busy});
      end
      step(1);
      checks++;
      if ({tl_start, ped_wait, busy} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL ped_after_start: tl_start,ped_wait,busy=%b, required 001",
                  {tl_start, ped_wait, busy});
      end
      ped_req = 1'b0;
      lightseq_in = amber_pat;
      step(5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ped_run_busy: busy=%b, required 1", busy);
      end
      lightseq_in = IDLE_PAT;
      step(1);
      checks++;
      if ({busy, served_count} !== {1'b0, 8'd1}) begin
         errors++;
         $display("[TB] FAIL ped_served: busy=%b served=%0d, required busy=0 served=1", busy, served_count);
      end
   endtask

   task automatic test_simultaneous;
      int w;
      ped_req = 1'b1;
      cyc_req = 1'b1;
      step(3);
      checks++;
      if ({ped_wait, cyc_wait} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL both_lamps: ped,cyc=%b, required 11", {ped_wait, cyc_wait});
      end
      wait_start(40, w);
      checks++;
      if (3 + w !== 17) begin
         errors++;
         $display("[TB] FAIL both_gap: start after %0d cycles, required 17", 3 + w);
      end
      ped_req = 1'b0;
      cyc_req = 1'b0;
      step(1);
      checks++;
      if ({tl_start, ped_wait, cyc_wait} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL both_clear: tl_start,ped,cyc=%b, required 000", {tl_start, ped_wait, cyc_wait});
      end
      finish_phase(3);
      checks++;
      if (served_count !== 8'd2) begin
         errors++;
         $display("[TB] FAIL both_served: served=%0d, required 2", served_count);
      end
   endtask

   task automatic test_req_during_run;
      int w;
      ped_req = 1'b1;
      wait_start(40, w);
      checks++;
      if (w !== 17) begin
         errors++;
         $display("[TB] FAIL min_gap: start after %0d cycles, required 17", w);
      end
      ped_req = 1'b0;
      step(1);
      lightseq_in = amber_pat;
      step(1);
      cyc_req = 1'b1;
      step(3);
      checks++;
      if (cyc_wait !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_cyc_lamp: cyc_wait=%b, required 1", cyc_wait);
      end
      cyc_req = 1'b0;
      step(4);
      checks++;
      if ({cyc_wait, busy, tl_start} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL run_cyc_hold: cyc,busy,tl_start=%b, required 110", {cyc_wait, busy, tl_start});
      end
      lightseq_in = IDLE_PAT;
      step(1);
      checks++;
      if ({cyc_wait, served_count} !== {1'b1, 8'd3}) begin
         errors++;
         $display("[TB] FAIL run_end: cyc=%b served=%0d, required cyc=1 served=3", cyc_wait, served_count);
      end
      wait_start(40, w);
      checks++;
      if (w !== 17) begin
         errors++;
         $display("[TB] FAIL cyc_min_gap: start after %0d cycles, required 17", w);
      end
      step(1);
      checks++;
      if (cyc_wait !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cyc_clear: cyc_wait=%b, required 0", cyc_wait);
      end
      finish_phase(2);
   endtask

   task automatic test_gap_restart;
      int w;
      ped_req = 1'b1;
      step(10);
      lightseq_in = amber_pat;
      step(1);
      lightseq_in = IDLE_PAT;
      wait_start(60, w);
      checks++;
      if (11 + w !== 28) begin
         errors++;
         $display("[TB] FAIL gap_restart: start after %0d cycles, required 28", 11 + w);
      end
      ped_req = 1'b0;
      step(1);
      finish_phase(2);
      checks++;
      if (served_count !== 8'd5) begin
         errors++;
         $display("[TB] FAIL gap_served: served=%0d, required 5", served_count);
      end
   endtask

   task automatic test_async_reset_and_run_timeout;
      int w;
      ped_req = 1'b1;
      wait_start(40, w);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({tl_start, ped_wait, cyc_wait, busy, fault, served_count} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %b, required all 0",
                  {tl_start, ped_wait, cyc_wait, busy, fault, served_count});
      end
      step(2);
      reset = 1'b1;
      step(3);
      checks++;
      if (ped_wait !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_edge_latch: ped_wait=%b, required 1", ped_wait);
      end
      wait_start(40, w);
      checks++;
      if (3 + w !== 17) begin
         errors++;
         $display("[TB] FAIL reset_min_gap: start after %0d cycles, required 17", 3 + w);
      end
      ped_req = 1'b0;
      step(1);
      lightseq_in = amber_pat;
      step(64);
      checks++;
      if ({fault, busy} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL run_timeout_early: fault,busy=%b, required 01", {fault, busy});
      end
      step(1);
      checks++;
      if ({fault, busy, tl_start} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL run_timeout: fault,busy,tl_start=%b, required 100", {fault, busy, tl_start});
      end
      lightseq_in = IDLE_PAT;
   endtask

   task automatic test_wait_leave_timeout;
      int w;
      int starts;
      starts = 0;
      apply_reset();
      ped_req = 1'b1;
      wait_start(40, w);
      ped_req = 1'b0;
      step(64);
      checks++;
      if ({fault, busy} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL leave_timeout_early: fault,busy=%b, required 01", {fault, busy});
      end
      step(1);
      checks++;
      if ({fault, busy, tl_start} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL leave_timeout: fault,busy,tl_start=%b, required 100", {fault, busy, tl_start});
      end
      cyc_req = 1'b1;
      step(3);
      checks++;
      if (cyc_wait !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fault_lamp: cyc_wait=%b, required 1", cyc_wait);
      end
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (tl_start === 1'b1) starts++;
      end
      cyc_req = 1'b0;
      checks++;
      if (starts !== 0 || fault !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fault_sticky: starts=%0d fault=%b, required starts=0 fault=1", starts, fault);
      end
   endtask

   task automatic test_saturation;
      int w;
      apply_reset();
      for (int i = 1; i <= 300; i++) begin
         ped_req = 1'b1;
         wait_start(40, w);
         ped_req = 1'b0;
         lightseq_in = amber_pat;
         step(2);
         lightseq_in = IDLE_PAT;
         step(1);
         if (i == 254) begin
            checks++;
            if (served_count !== 8'd254) begin
               errors++;
               $display("[TB] FAIL count_254: served=%0d, required 254", served_count);
            end
         end
         if (i == 255) begin
            checks++;
            if (served_count !== 8'd255) begin
               errors++;
               $display("[TB] FAIL count_255: served=%0d, required 255", served_count);
            end
         end
      end
      checks++;
      if (served_count !== 8'd255) begin
         errors++;
         $display("[TB] FAIL count_saturate: served=%0d, required 255", served_count);
      end
   endtask

   initial begin
      amber_pat          = '0;
      amber_pat[TRAF_A]  = 1'b1;
      amber_pat[CROSS_R] = 1'b1;
      test_reset();
      test_ped_request();
      test_simultaneous();
      test_req_during_run();
      test_gap_restart();
      test_async_reset_and_run_timeout();
      test_wait_leave_timeout();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
